// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; MTHI/MTLO write in one cycle.
// Latency: Done WIDTH+2 edges after the Start edge, Hi/Lo visible with Done.
// Backpressure: Busy high while not IDLE; Start ignored until back in IDLE.
module mult_div_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]       opb_q;
  logic                   neg_q, neg_r_q, b_zero_q, is_div_q;
  logic [WIDTH-1:0]       hi_q, lo_q;
  logic                   dbz_q;

  logic                   start_ok, start_arith, start_move;
  logic                   op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]       abs_a, abs_b;
  logic                   iterating;
  logic [WIDTH:0]         mul_sum, div_trial;
  logic                   div_fits;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix, rem_fix;

  assign start_ok    = (state_q == S_IDLE) && Start;
  assign start_arith = start_ok && !Op[2];
  assign start_move  = start_ok && (Op[2:1] == 2'b10);

  assign op_signed = !Op[0];
  assign a_neg     = op_signed && A[WIDTH-1];
  assign b_neg     = op_signed && B[WIDTH-1];
  assign abs_a     = a_neg ? -A : A;
  assign abs_b     = b_neg ? -B : B;

  assign iterating = ((state_q == S_MUL) || (state_q == S_DIV)) && (cnt_q != CNT_W'(WIDTH));

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
  // A zero divisor always "fits", so the remainder ends up holding |A| unchanged.
  assign div_fits  = !div_trial[WIDTH] || b_zero_q;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = b_zero_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_arith) state_d = Op[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV: begin
        if (Flush)                           state_d = S_IDLE;
        else if (cnt_q == CNT_W'(WIDTH))     state_d = S_FIXUP;
      end
      S_FIXUP: state_d = Flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else if (start_arith) begin
      cnt_q    <= '0;
      acc_q    <= {{WIDTH{1'b0}}, (Op[1] ? abs_a : abs_b)};
      opb_q    <= Op[1] ? abs_b : abs_a;
      neg_q    <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      b_zero_q <= (B == '0);
      is_div_q <= Op[1];
      dbz_q    <= 1'b0;
    end else if (start_move) begin
      if (Op[0]) lo_q <= A;
      else       hi_q <= A;
      dbz_q <= 1'b0;
    end else if (iterating) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == S_MUL)
        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
      else if (div_fits)
        acc_q <= {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_q <= {acc_q[2*WIDTH-2:0], 1'b0};
    end else if ((state_q == S_FIXUP) && !Flush) begin
      if (is_div_q) begin
        hi_q  <= rem_fix;
        lo_q  <= quo_fix;
        dbz_q <= b_zero_q;
      end else begin
        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
        lo_q <= prod_fix[WIDTH-1:0];
      end
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: fixed latency, signed/unsigned results,
// divide-by-zero, overflow, MTHI/MTLO, Flush and asynchronous reset abort.
module tb_mult_div_unit;
  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;
  int          errors = 0;
  int          checks = 0;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  mult_div_unit dut (
    .Clk(clk), .Rst(rst), .Start(start), .Op(op), .A(a), .B(b), .Flush(flush),
    .Busy(busy), .Done(done), .DivByZero(dbz), .Hi(hi), .Lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one multi-cycle op, measure edges until Done, capture results, check the pulse ends.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, output logic [31:0] rhi,
                        output logic [31:0] rlo, output logic rdbz);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h0; b = 32'h0;
    check({tag, "_busy"}, 64'(busy), 64'(1));
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(34));
    rhi = hi; rlo = lo; rdbz = dbz;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'({done, busy}), 64'(0));
  endtask

  logic [31:0] rh, rl;
  logic        rd;
  int          saw_done;

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b0; a = '0; b = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz",  64'(dbz),  64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    @(negedge clk); rst = 1'b1;

    run_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'h00000005, rh, rl, rd);
    check("mult_m3x5_hilo", {rh, rl}, 64'hFFFFFFFF_FFFFFFF1);

    run_op("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, rd);
    check("multu_ff_hilo", {rh, rl}, 64'hFFFFFFFE_00000001);

    run_op("mult_m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, rd);
    check("mult_m1_hilo", {rh, rl}, 64'h00000000_00000001);

    run_op("div_m7", OP_DIV, 32'hFFFFFFF9, 32'h00000002, rh, rl, rd);
    check("div_m7_hilo", {rh, rl}, 64'hFFFFFFFF_FFFFFFFD);

    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, rh, rl, rd);
    check("div_ovf_hilo", {rh, rl}, 64'h00000000_80000000);
    check("div_ovf_dbz", 64'(rd), 64'(0));

    run_op("divu_z", OP_DIVU, 32'h0000000A, 32'h00000000, rh, rl, rd);
    check("divu_z_hilo", {rh, rl}, 64'h0000000A_FFFFFFFF);
    check("divu_z_dbz", 64'(rd), 64'(1));

    @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h12345678);
    check("mtlo_hi", 64'(hi), 64'h0000000A);
    check("mtlo_busy", 64'(busy), 64'(0));
    check("mtlo_dbz", 64'(dbz), 64'(0));

    // DIVU 100/7, a stray MTHI while busy, then Flush after iteration 10.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_state", 64'({busy, done}), 64'(0));
    check("flush_hilo", {hi, lo}, 64'h0000000A_12345678);
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    check("flush_no_done", 64'(saw_done), 64'(0));

    // Start wins over Flush in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("mthi_flush_hi", 64'(hi), 64'hCAFEF00D);

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'h3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("arst_state", 64'({busy, done}), 64'(0));
    check("arst_hilo", {hi, lo}, 64'(0));
    @(negedge clk); rst = 1'b1;

    run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, rh, rl, rd);
    check("multu_6x7_hilo", {rh, rl}, 64'h00000000_0000002A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
